mem_arbiter: RTL
================

# mem_arbiter

Two-requester arbiter that shares the single data-memory port (16K RAM + screen + keyboard map, 15-bit word address) between the CPU data port and a screen/DMA engine. CPU accesses are single-beat. The DMA requester is granted in bursts of up to BURST_LEN beats, so that neither side can starve the other. The block sits between the CPU/DMA masters and the Memory block in the top-level computer, and returns registered read data with a valid strobe.

## Interface
- BURST_LEN, 4: maximum consecutive DMA grants while the CPU is also requesting; legal range 1..15.
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  reset is asynchronous and active-low.
- c_req  in  1  CPU request; held with c_we/c_addr/c_wdata stable until c_gnt.
- c_we  in  1  CPU write enable (1 = write, 0 = read).
- c_addr  in  15  CPU word address.
- c_wdata  in  16  CPU write data.
- c_gnt  out  1  CPU granted this cycle (combinational).
- c_rvalid  out  1  registered; CPU read data valid.
- c_rdata  out  16  registered CPU read data.
- d_req, d_we, d_addr[14:0], d_wdata[15:0]  in  DMA request group; same rules as CPU.
- d_gnt  out  1  DMA granted this cycle (combinational).
- d_rvalid  out  1  registered; DMA read data valid.
- d_rdata  out  16  registered DMA read data.
- mem_in  out  16  write data to memory (wdata of the granted requester, else 0).
- mem_load  out  1  gnt & we of the granted requester.
- mem_address  out  15  address of the granted requester, else 0.
- mem_out  in  16  combinational memory read data for mem_address.

## Operation
- State register `own`: IDLE, CPU, DMA. Beat counter `cnt` (4 bits) counts DMA grants in the current burst.
- Per-cycle grant decision (combinational from own, cnt, c_req, d_req):
  - neither request: no grant; next own=IDLE, cnt←0.
  - c_req only: c_gnt=1; next own=CPU, cnt←0.
  - d_req only: d_gnt=1; next own=DMA; cnt←(own==DMA) ? min(cnt+1, BURST_LEN) : 1.
  - both requests: CPU wins iff own==IDLE, or (own==DMA and cnt==BURST_LEN). CPU win → own=CPU, cnt←0. DMA win → own=DMA, cnt←(own==DMA) ? cnt+1 : 1.
- At most one of c_gnt/d_gnt is 1; a grant is never issued without its req.
- Only the granted requester drives the memory port (mem_address, mem_in, mem_load); all three are 0 when there is no grant.
- Reads: on a granted read (we=0), mem_out is captured into x_rdata at the clock edge, and x_rvalid=1 for exactly the next cycle. Otherwise x_rvalid=0 and x_rdata holds its last value.
- Writes: the memory commits mem_in at the edge ending the grant cycle. No rvalid is produced for writes.
- If a DMA burst is interrupted by d_req dropping, the burst ends immediately and the next DMA grant restarts with cnt=1.

## Timing
- Grant latency: 0 cycles when uncontended. Read-data latency: 1 cycle after the grant cycle.
- Worst-case CPU wait while DMA streams continuously: BURST_LEN cycles. Worst-case DMA wait: 1 cycle.
- BURST_LEN=1 gives strict alternation under continuous contention.
- Reset asserted (reset=0), asynchronously: own=IDLE, cnt=0, c_rvalid=d_rvalid=0, c_rdata=d_rdata=0. c_gnt, d_gnt and mem_load are forced to 0 while reset is low, regardless of requests.
- Reset mid-burst or mid-read: a pending rvalid is discarded. After release, arbitration restarts from IDLE, so the CPU wins the first contended cycle.
- Requests sampled in the first cycle after reset deassertion are arbitrated normally.

## Test plan
- Reset: hold reset=0 with c_req=d_req=1 → c_gnt=d_gnt=mem_load=0, both rvalid=0. Release → first cycle c_gnt=1.
- CPU-only read/write: c_req, c_we=1, c_addr=0x0010, c_wdata=0x1234, then read 0x0010 → c_gnt both cycles; c_rvalid=1 one cycle after the read with c_rdata=0x1234.
- Continuous contention, BURST_LEN=4, both reqs held high from IDLE → grant sequence C,D,D,D,D,C,D,D,D,D,… d_rvalid on every cycle after a DMA read grant.
- DMA-only stream of 10 reads from 0x4000 → d_gnt every cycle, cnt saturates at 4. Raise c_req at beat 7 → CPU granted on that cycle.
- Burst interrupt: d_req drops after 2 DMA beats while c_req is high → CPU granted next cycle. DMA returns → fresh burst of up to 4 beats.
- Async reset mid-burst (cnt=2, read in flight) → rvalid never asserts for that read; own=IDLE, cnt=0 immediately, with no clock edge required.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the shared data-memory port: single-beat CPU accesses,
// DMA bursts capped at BURST_LEN beats under contention, registered read return.
module mem_arbiter #(
    parameter int unsigned BURST_LEN = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_c_req,
    input  logic        i_c_we,
    input  logic [14:0] i_c_addr,
    input  logic [15:0] i_c_wdata,
    output logic        o_c_gnt,
    output logic        o_c_rvalid,
    output logic [15:0] o_c_rdata,
    input  logic        i_d_req,
    input  logic        i_d_we,
    input  logic [14:0] i_d_addr,
    input  logic [15:0] i_d_wdata,
    output logic        o_d_gnt,
    output logic        o_d_rvalid,
    output logic [15:0] o_d_rdata,
    output logic [15:0] o_mem_in,
    output logic        o_mem_load,
    output logic [14:0] o_mem_address,
    input  logic [15:0] i_mem_out
);

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } own_t;

    localparam logic [3:0] LP_BURST = 4'(BURST_LEN);

    own_t        r_own;
    own_t        w_own_next;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;
    logic        w_cpu_pri;
    logic        w_c_gnt;
    logic        w_d_gnt;
    logic        r_c_rvalid;
    logic        r_d_rvalid;
    logic [15:0] r_c_rdata;
    logic [15:0] r_d_rdata;

    // CPU takes contended cycles only from idle or once the DMA burst is exhausted.
    // Grants are gated by reset so nothing reaches memory while reset is held.
    always_comb begin
        w_cpu_pri = (r_own == OWN_IDLE) || ((r_own == OWN_DMA) && (r_cnt == LP_BURST));
        w_c_gnt   = i_rst_n & i_c_req & (~i_d_req | w_cpu_pri);
        w_d_gnt   = i_rst_n & i_d_req & ~w_c_gnt;
    end

    always_comb begin
        w_own_next = OWN_IDLE;
        w_cnt_next = 4'd0;
        if (w_c_gnt) begin
            w_own_next = OWN_CPU;
        end else if (w_d_gnt) begin
            w_own_next = OWN_DMA;
            if (r_own != OWN_DMA) begin
                w_cnt_next = 4'd1;
            end else if (r_cnt >= LP_BURST) begin
                w_cnt_next = LP_BURST;
            end else begin
                w_cnt_next = r_cnt + 4'd1;
            end
        end
    end

    always_comb begin
        o_mem_address = 15'd0;
        o_mem_in      = 16'd0;
        o_mem_load    = 1'b0;
        if (w_c_gnt) begin
            o_mem_address = i_c_addr;
            o_mem_in      = i_c_wdata;
            o_mem_load    = i_c_we;
        end else if (w_d_gnt) begin
            o_mem_address = i_d_addr;
            o_mem_in      = i_d_wdata;
            o_mem_load    = i_d_we;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_own      <= OWN_IDLE;
            r_cnt      <= 4'd0;
            r_c_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            r_c_rdata  <= 16'd0;
            r_d_rdata  <= 16'd0;
        end else begin
            r_own      <= w_own_next;
            r_cnt      <= w_cnt_next;
            r_c_rvalid <= w_c_gnt & ~i_c_we;
            r_d_rvalid <= w_d_gnt & ~i_d_we;
            if (w_c_gnt && !i_c_we) begin
                r_c_rdata <= i_mem_out;
            end
            if (w_d_gnt && !i_d_we) begin
                r_d_rdata <= i_mem_out;
            end
        end
    end

    assign o_c_gnt    = w_c_gnt;
    assign o_d_gnt    = w_d_gnt;
    assign o_c_rvalid = r_c_rvalid;
    assign o_d_rvalid = r_d_rvalid;
    assign o_c_rdata  = r_c_rdata;
    assign o_d_rdata  = r_d_rdata;

endmodule
